// File: rtl/onchip_read_master_pkg.sv
// Shared types and sizing helpers for the burst weight read master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onchip_read_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bits needed for a counter that must hold the value n itself (0..n).
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/onchip_read_master_weight_burst_fifo.sv
// Synchronous FIFO holding returned weight words until the PE array takes them.
// Latency: a push at edge t is visible at head_dat / !empty from cycle t+1.
// Backpressure: push and pop may coincide at any occupancy, including full.
module weight_read_fifo
    import onchip_read_master_pkg::*;
#(
    parameter  int DATA_W     = 1024,
    parameter  int FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int FCNT_W     = cnt_width(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              full,
    output logic              empty,
    output logic [FCNT_W-1:0] count
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + FCNT_W'(1);
        else if (pop && !push) count_d = count_q - FCNT_W'(1);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (count_q == FCNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/onchip_read_master_weight_burst.sv
// Burst weight read master: pipelined Avalon-MM reads of word_count words from base_addr, streamed to the PE array.
// Latency: first avm_read one cycle after start; a returned word is on out_valid one cycle after readdatavalid.
// Backpressure: out_ready low fills the FIFO and credit halts new reads; ONCHIP_READ_MASTER_PERF_CNT_EN adds stall/bp counters.
module onchip_read_master_weight_burst
    import onchip_read_master_pkg::*;
#(
    parameter int DATA_W          = 1024,
    parameter int ADDR_W          = 17,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_chipselect,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef ONCHIP_READ_MASTER_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         bp_cycles
`endif
);

    localparam int OUT_W  = cnt_width(MAX_OUTSTANDING);
    localparam int FCNT_W = cnt_width(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic                read_q, read_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept, rdv_eff, credit, start_ok;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCNT_W-1:0]   fifo_count, fifo_count_nxt;

    weight_read_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (avm_readdata),
        .pop      (fifo_pop),
        .head_dat (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Handshakes, in-flight accounting and the credit test for the next cycle's request.
    always_comb begin
        accept    = read_q && !avm_waitrequest;
        // Data with nothing in flight is left over from an aborted job.
        rdv_eff   = avm_readdatavalid && (outstanding_q != '0);
        fifo_pop  = !fifo_empty && out_ready;
        fifo_push = rdv_eff && (!fifo_full || fifo_pop);
        start_ok  = start && (state_q == IDLE);

        outstanding_d = outstanding_q;
        if (accept && !rdv_eff)      outstanding_d = outstanding_q + OUT_W'(1);
        else if (!accept && rdv_eff) outstanding_d = outstanding_q - OUT_W'(1);

        fifo_count_nxt = fifo_count;
        if (fifo_push && !fifo_pop)      fifo_count_nxt = fifo_count + FCNT_W'(1);
        else if (!fifo_push && fifo_pop) fifo_count_nxt = fifo_count - FCNT_W'(1);

        // Every in-flight read already owns a FIFO slot, so a new one needs a free slot.
        credit = ((32'(outstanding_d) + 32'(fifo_count_nxt)) < 32'(FIFO_DEPTH)) &&
                 (32'(outstanding_d) < 32'(MAX_OUTSTANDING));
    end

    // Job sequencing: next state, address/remaining bookkeeping and the registered request.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        read_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && fifo_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A stalled request is held untouched; its credit was reserved when it was raised.
        if (read_q && avm_waitrequest) read_d = 1'b1;
        else read_d = (state_d == ISSUE) && (remaining_d != '0) && credit;
    end

    // Master state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            read_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            read_q        <= read_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_chipselect = read_q;
    assign avm_byteenable = '1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign out_valid      = !fifo_empty;

`ifdef ONCHIP_READ_MASTER_PERF_CNT_EN
    logic [31:0] stall_q, stall_d, bp_q, bp_d;

    // Saturating stall / backpressure counters, cleared by each accepted start.
    always_comb begin
        stall_d = stall_q;
        bp_d    = bp_q;
        if (start_ok) begin
            stall_d = '0;
            bp_d    = '0;
        end else begin
            if (busy_q && read_q && avm_waitrequest && (stall_q != '1)) stall_d = stall_q + 32'd1;
            if (out_valid && !out_ready && (bp_q != '1))               bp_d    = bp_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            bp_q    <= '0;
        end else begin
            stall_q <= stall_d;
            bp_q    <= bp_d;
        end
    end

    assign stall_cycles = stall_q;
    assign bp_cycles    = bp_q;
`else
    // start_ok only feeds the optional counters.
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule
